bullet_pool: RTL and testbench

BULLET_POOL -- requirements
Module: bullet_pool

---
 rtl/bullet_pkg.sv | 28 ++
 rtl/bullet_slot.sv | 57 +++++
 rtl/bullet_pool.sv | 99 +++++++++
 tb/tb_bullet_pool.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared constants and the per-slot record used by the bullet pool and its slots.
package bullet_pkg;

    localparam int DEF_NUM_BULLETS = 4;
    localparam int DEF_Y_STEP      = 4;
    localparam int DEF_Y_START     = 136;
    localparam int DEF_Y_MIN       = 0;
    localparam int DEF_COOLDOWN    = 8;

    localparam int COORD_W = 10;
    localparam int CD_W    = 8;

    typedef struct packed {
        logic               active;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } slot_t;

    // Parked state of a slot that is not in flight.
    function automatic slot_t idle_slot(input int y_start);
        slot_t s;
        s.active = 1'b0;
        s.x      = '0;
        s.y      = COORD_W'(y_start);
        return s;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: launch when idle, climb Y_STEP per frame, park on hit or at the ceiling.
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int Y_STEP  = DEF_Y_STEP,
    parameter int Y_START = DEF_Y_START,
    parameter int Y_MIN   = DEF_Y_MIN
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               launch_i,
    input  logic [COORD_W-1:0] launch_x_i,
    input  logic               hit_i,
    output logic               active_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o
);

    // One extra bit so Y_MIN + Y_STEP never wraps against a 10-bit Y.
    localparam logic [COORD_W:0] CEIL_LIMIT = (COORD_W + 1)'(Y_MIN + Y_STEP);

    slot_t slot_q;
    slot_t slot_d;
    logic  can_move;

    assign can_move = {1'b0, slot_q.y} >= CEIL_LIMIT;

    always_comb begin
        // NOTE: default first so every path assigns slot_d and no latch is inferred.
        slot_d = slot_q;
        if (slot_q.active) begin
            if (hit_i || !can_move) begin
                slot_d = idle_slot(Y_START);
            end else begin
                slot_d.y = slot_q.y - COORD_W'(Y_STEP);
            end
        end else if (launch_i) begin
            slot_d.active = 1'b1;
            slot_d.x      = launch_x_i;
            slot_d.y      = COORD_W'(Y_START);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        // NOTE: non-blocking so every slot and the pool update from the same pre-edge state.
        if (Reset) begin
            slot_q <= idle_slot(Y_START);
        end else begin
            slot_q <= slot_d;
        end
    end

    assign active_o = slot_q.active;
    assign x_o      = slot_q.x;
    assign y_o      = slot_q.y;

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: fire-edge detection, cooldown, lowest-free slot allocation over NUM_BULLETS slots.
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = DEF_NUM_BULLETS,
    parameter int Y_STEP      = DEF_Y_STEP,
    parameter int Y_START     = DEF_Y_START,
    parameter int Y_MIN       = DEF_Y_MIN,
    parameter int COOLDOWN    = DEF_COOLDOWN
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic                           fire,
    input  logic [COORD_W-1:0]             player_X,
    input  logic [NUM_BULLETS-1:0]         hit,
    output logic [NUM_BULLETS*COORD_W-1:0] bullet_X,
    output logic [NUM_BULLETS*COORD_W-1:0] bullet_Y,
    output logic [NUM_BULLETS-1:0]         bullet_active,
    output logic                           fire_accepted,
    output logic                           fire_dropped
);

    logic                   fire_q;
    logic                   armed_q;
    logic [CD_W-1:0]        cooldown_q;
    logic [CD_W-1:0]        cooldown_d;
    logic                   accepted_q;
    logic                   dropped_q;

    logic                   fire_edge;
    logic                   accept;
    logic                   free_found;
    logic [NUM_BULLETS-1:0] lowest_free;
    logic [NUM_BULLETS-1:0] launch;

    // armed_q stays low until fire is seen low, so a key held through reset is not an edge.
    assign fire_edge = fire & ~fire_q & armed_q;

    always_comb begin
        lowest_free = '0;
        free_found  = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!bullet_active[i] && !free_found) begin
                lowest_free[i] = 1'b1;
                free_found     = 1'b1;
            end
        end
    end

    assign accept = fire_edge && (cooldown_q == '0) && free_found;
    assign launch = accept ? lowest_free : '0;

    always_comb begin
        if (accept) begin
            cooldown_d = CD_W'(COOLDOWN);
        end else if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end else begin
            cooldown_d = cooldown_q;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            fire_q     <= 1'b0;
            armed_q    <= 1'b0;
            cooldown_q <= '0;
            accepted_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            fire_q     <= fire;
            armed_q    <= armed_q | ~fire;
            cooldown_q <= cooldown_d;
            accepted_q <= accept;
            dropped_q  <= fire_edge & ~accept;
        end
    end

    assign fire_accepted = accepted_q;
    assign fire_dropped  = dropped_q;

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .Y_STEP  (Y_STEP),
            .Y_START (Y_START),
            .Y_MIN   (Y_MIN)
        ) u_slot (
            .frame_clk  (frame_clk),
            .Reset      (Reset),
            .launch_i   (launch[g]),
            .launch_x_i (player_X),
            .hit_i      (hit[g]),
            .active_o   (bullet_active[g]),
            .x_o        (bullet_X[g*COORD_W +: COORD_W]),
            .y_o        (bullet_Y[g*COORD_W +: COORD_W])
        );
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: two instances (default launch height and a raised one) checked per frame against a model.
module tb_bullet_pool;

    localparam int N         = 4;
    localparam int P_STEP    = 4;
    localparam int P_MIN     = 0;
    localparam int P_COOL    = 8;
    localparam int P_START_A = 136;
    localparam int P_START_B = 1000;

    int n_cmp  = 0;
    int n_fail = 0;

    logic frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    logic            rst_a  = 1'b0;
    logic            fire_a = 1'b0;
    logic [9:0]      px_a   = '0;
    logic [N-1:0]    hit_a  = '0;
    logic [N*10-1:0] bx_a, by_a;
    logic [N-1:0]    act_a;
    logic            acc_a, drp_a;

    logic            rst_b  = 1'b0;
    logic            fire_b = 1'b0;
    logic [9:0]      px_b   = '0;
    logic [N-1:0]    hit_b  = '0;
    logic [N*10-1:0] bx_b, by_b;
    logic [N-1:0]    act_b;
    logic            acc_b, drp_b;

    bullet_pool #(
        .NUM_BULLETS (N), .Y_STEP (P_STEP), .Y_START (P_START_A), .Y_MIN (P_MIN), .COOLDOWN (P_COOL)
    ) dut_a (
        .frame_clk (frame_clk), .Reset (rst_a), .fire (fire_a), .player_X (px_a), .hit (hit_a),
        .bullet_X (bx_a), .bullet_Y (by_a), .bullet_active (act_a),
        .fire_accepted (acc_a), .fire_dropped (drp_a)
    );

    bullet_pool #(
        .NUM_BULLETS (N), .Y_STEP (P_STEP), .Y_START (P_START_B), .Y_MIN (P_MIN), .COOLDOWN (P_COOL)
    ) dut_b (
        .frame_clk (frame_clk), .Reset (rst_b), .fire (fire_b), .player_X (px_b), .hit (hit_b),
        .bullet_X (bx_b), .bullet_Y (by_b), .bullet_active (act_b),
        .fire_accepted (acc_b), .fire_dropped (drp_b)
    );

    // Reference model: plain integer state per instance, stepped once per frame.
    int m_act [2][N];
    int m_x   [2][N];
    int m_y   [2][N];
    int m_cd  [2];
    bit m_fq  [2];
    bit m_arm [2];
    bit m_acc [2];
    bit m_drp [2];

    function automatic int start_of(input int d);
        return (d == 0) ? P_START_A : P_START_B;
    endfunction

    task automatic model_reset(input int d);
        for (int i = 0; i < N; i++) begin
            m_act[d][i] = 0;
            m_x[d][i]   = 0;
            m_y[d][i]   = start_of(d);
        end
        m_cd[d]  = 0;
        m_fq[d]  = 1'b0;
        m_arm[d] = 1'b0;
        m_acc[d] = 1'b0;
        m_drp[d] = 1'b0;
    endtask

    task automatic model_step(input int d, input bit f, input int px, input bit [N-1:0] h);
        bit edge_seen;
        bit take;
        int free_slot;
        edge_seen = f && !m_fq[d] && m_arm[d];
        free_slot = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_act[d][i] == 0) free_slot = i;
        end
        take = edge_seen && (m_cd[d] == 0) && (free_slot >= 0);
        for (int i = 0; i < N; i++) begin
            if (m_act[d][i] != 0) begin
                if (h[i] || (m_y[d][i] < P_MIN + P_STEP)) begin
                    m_act[d][i] = 0;
                    m_x[d][i]   = 0;
                    m_y[d][i]   = start_of(d);
                end else begin
                    m_y[d][i] = m_y[d][i] - P_STEP;
                end
            end
        end
        if (take) begin
            m_act[d][free_slot] = 1;
            m_x[d][free_slot]   = px;
            m_y[d][free_slot]   = start_of(d);
        end
        if (take) m_cd[d] = P_COOL;
        else if (m_cd[d] > 0) m_cd[d] = m_cd[d] - 1;
        m_acc[d] = take;
        m_drp[d] = edge_seen && !take;
        m_fq[d]  = f;
        if (!f) m_arm[d] = 1'b1;
    endtask

    always @(posedge frame_clk or posedge rst_a) begin
        if (rst_a) model_reset(0);
        else model_step(0, fire_a, int'(px_a), hit_a);
    end

    always @(posedge frame_clk or posedge rst_b) begin
        if (rst_b) model_reset(1);
        else model_step(1, fire_b, int'(px_b), hit_b);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] field(input logic [N*10-1:0] v, input int i);
        return v[i*10 +: 10];
    endfunction

    task automatic compare_dut(input int d);
        logic [N*10-1:0] bx, by;
        logic [N-1:0]    ba;
        logic            acc, drp;
        if (d == 0) begin
            bx = bx_a; by = by_a; ba = act_a; acc = acc_a; drp = drp_a;
        end else begin
            bx = bx_b; by = by_b; ba = act_b; acc = acc_b; drp = drp_b;
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("dut%0d active[%0d]", d, i), 32'(ba[i]), m_act[d][i]);
            check($sformatf("dut%0d X[%0d]", d, i), 32'(field(bx, i)), m_x[d][i]);
            check($sformatf("dut%0d Y[%0d]", d, i), 32'(field(by, i)), m_y[d][i]);
        end
        check($sformatf("dut%0d fire_accepted", d), 32'(acc), 32'(m_acc[d]));
        check($sformatf("dut%0d fire_dropped", d), 32'(drp), 32'(m_drp[d]));
    endtask

    always @(negedge frame_clk) begin
        compare_dut(0);
        compare_dut(1);
    end

    // Advance n frames; inputs change 1 time unit after a falling edge.
    task automatic next(input int n);
        repeat (n) @(negedge frame_clk);
        #1;
    endtask

    initial begin
        int n_acc;
        int n_drp;

        #1 rst_a = 1'b1; rst_b = 1'b1;
        #20 rst_a = 1'b0; rst_b = 1'b0;
        next(2);
        check("reset active", 32'(act_a), 0);
        check("reset X", 32'(bx_a), 0);
        check("reset Y0", 32'(field(by_a, 0)), 136);
        check("reset accepted", 32'(acc_a), 0);

        // First launch and its flight with player_X moving away.
        fire_a = 1'b1; px_a = 10'd200;
        next(1);
        check("launch active", 32'(act_a), 32'b0001);
        check("launch X0", 32'(field(bx_a, 0)), 200);
        check("launch Y0", 32'(field(by_a, 0)), 136);
        check("launch accepted", 32'(acc_a), 1);
        fire_a = 1'b0; px_a = 10'd50;
        next(2);
        fire_a = 1'b1;
        next(1);
        check("flight Y0", 32'(field(by_a, 0)), 124);
        check("flight X0 latched", 32'(field(bx_a, 0)), 200);
        check("cooldown drop", 32'(drp_a), 1);
        check("cooldown no launch", 32'(act_a), 32'b0001);

        // Edge nine frames after the launch clears the cooldown.
        fire_a = 1'b0;
        next(5);
        fire_a = 1'b1;
        next(1);
        check("frame9 accepted", 32'(acc_a), 1);
        check("frame9 active", 32'(act_a), 32'b0011);
        check("frame9 X1", 32'(field(bx_a, 1)), 50);
        check("frame9 Y0", 32'(field(by_a, 0)), 100);

        // Fire held: no further launches, no drops.
        n_acc = 0; n_drp = 0;
        repeat (19) begin
            next(1);
            n_acc += int'(acc_a);
            n_drp += int'(drp_a);
        end
        check("held launches", n_acc, 0);
        check("held drops", n_drp, 0);
        fire_a = 1'b0;

        // Hits on idle slots are ignored.
        hit_a = 4'b1100;
        next(1);
        check("idle hit ignored", 32'(act_a), 32'b0011);
        check("idle hit Y0", 32'(field(by_a, 0)), 20);
        hit_a = '0;

        // Ceiling: 4 -> 0 -> parked.
        next(4);
        check("ceil Y0=4", 32'(field(by_a, 0)), 4);
        next(1);
        check("ceil Y0=0", 32'(field(by_a, 0)), 0);
        check("ceil still active", 32'(act_a[0]), 1);
        next(1);
        check("ceil parked active", 32'(act_a[0]), 0);
        check("ceil parked Y0", 32'(field(by_a, 0)), 136);
        check("ceil parked X0", 32'(field(bx_a, 0)), 0);

        // Hit on an active slot parks it.
        hit_a = 4'b0010;
        next(1);
        check("hit active", 32'(act_a), 0);
        check("hit X1", 32'(field(bx_a, 1)), 0);
        check("hit Y1", 32'(field(by_a, 1)), 136);
        hit_a = '0;

        // Mid-flight asynchronous reset, fire held through release.
        fire_a = 1'b1; px_a = 10'd321;
        next(1);
        check("relaunch X0", 32'(field(bx_a, 0)), 321);
        fire_a = 1'b0;
        next(2);
        #2 rst_a = 1'b1;
        #1;
        check("async rst active", 32'(act_a), 0);
        check("async rst X", 32'(bx_a), 0);
        check("async rst Y", 32'(by_a), 32'(40'd0) | 32'(field(by_a, 0) == 10'd136 && field(by_a, 3) == 10'd136) ? 32'(by_a) : 32'hFFFF_FFFF);
        check("async rst Y3", 32'(field(by_a, 3)), 136);
        check("async rst accepted", 32'(acc_a), 0);
        fire_a = 1'b1; rst_a = 1'b0;
        next(3);
        check("held through reset", 32'(act_a), 0);
        fire_a = 1'b0;
        next(1);
        fire_a = 1'b1;
        next(1);
        check("post-reset launch", 32'(acc_a), 1);
        check("post-reset X0", 32'(field(bx_a, 0)), 321);
        fire_a = 1'b0;

        // Instance B: five edges nine frames apart fill the pool, the fifth is dropped.
        for (int k = 0; k < 5; k++) begin
            px_b = 10'(100 + 10 * k);
            fire_b = 1'b1;
            next(1);
            check($sformatf("fill accepted %0d", k), 32'(acc_b), (k < 4) ? 1 : 0);
            check($sformatf("fill dropped %0d", k), 32'(drp_b), (k == 4) ? 1 : 0);
            check($sformatf("fill active %0d", k), 32'(act_b), (k < 4) ? ((1 << (k + 1)) - 1) : 15);
            fire_b = 1'b0;
            next(8);
        end
        for (int k = 0; k < N; k++) begin
            check($sformatf("fill X%0d", k), 32'(field(bx_b, k)), 100 + 10 * k);
        end

        // Hit on slot1 with a simultaneous edge: freed slot is not reused this frame.
        hit_b = 4'b0010; fire_b = 1'b1;
        next(1);
        check("hit+edge dropped", 32'(drp_b), 1);
        check("hit+edge accepted", 32'(acc_b), 0);
        check("hit+edge active", 32'(act_b), 32'b1101);
        check("hit+edge Y1", 32'(field(by_b, 1)), 1000);
        hit_b = '0;
        next(1);
        fire_b = 1'b0;
        next(1);
        px_b = 10'd77; fire_b = 1'b1;
        next(1);
        check("refill accepted", 32'(acc_b), 1);
        check("refill active", 32'(act_b), 32'b1111);
        check("refill X1", 32'(field(bx_b, 1)), 77);
        fire_b = 1'b0;
        next(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
